// File: rtl/mips_mon_pkg.sv
// mips_mon_pkg: shared types and constants for the MIPS run-control monitor.
//   mon_state_e  : run-control states (IDLE, RUN, HALTED)
//   halt_cause_e : reported halt reason (NONE=0, NOP=1, TIMEOUT=2)
//   MIPS_NOP     : the canonical MIPS NOP encoding (sll $0,$0,0)
package mips_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_NOP     = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } halt_cause_e;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_trace_fifo.sv
// mips_trace_fifo: show-ahead FIFO holding retired-instruction trace entries.
// Ports:
//   clk, reset (async, active-low), flush (sync clear of pointers)
//   push, push_data : write one entry when not full (or when popping while full)
//   pop             : drop the head; ignored while empty
//   full, empty     : occupancy flags
//   head            : current head entry, valid whenever empty is low
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module mips_trace_fifo
    import mips_mon_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_pop_s;
    logic             do_push_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage and pointer update; storage is cleared on reset so head reads 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/mips_run_monitor.sv
// mips_run_monitor: run-control and trace monitor fed from the retire stage.
// Counts RUN cycles and retired instructions, halts after NOP_LIMIT
// consecutive retired NOPs (cause 1) or MAX_CYCLES RUN cycles (cause 2),
// and traces non-NOP retirements as {instr, alu_result}.
// Ports:
//   clk, reset (async, active-low), start (arm / re-arm pulse)
//   instr_valid, instr, alu_result : retire-stage inputs
//   running, halt, halt_cause, cycle_count, instr_count : run status
//   trace_rd, trace_valid, trace_data, trace_overflow   : trace FIFO access
// Build option: MIPS_TRACE_FIFO_EN builds the trace FIFO; without it the
// trace outputs are tied to 0 and trace_rd is ignored.
module mips_run_monitor
    import mips_mon_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NOP_LIMIT   = 4,
    parameter int MAX_CYCLES  = 1000,
    parameter int CYCLE_W     = 16,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                instr_valid,
    input  logic [DATA_W-1:0]   instr,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                running,
    output logic                halt,
    output logic [1:0]          halt_cause,
    output logic [CYCLE_W-1:0]  cycle_count,
    output logic [CYCLE_W-1:0]  instr_count,
    input  logic                trace_rd,
    output logic                trace_valid,
    output logic [2*DATA_W-1:0] trace_data,
    output logic                trace_overflow
);

    localparam int NOP_W = $clog2(NOP_LIMIT + 1);
    localparam logic [NOP_W-1:0]   NOP_ONE = {{(NOP_W-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_W-1:0] CYC_ONE = {{(CYCLE_W-1){1'b0}}, 1'b1};

    mon_state_e          state_r;
    halt_cause_e         cause_r;
    logic [CYCLE_W-1:0]  cycle_count_r;
    logic [CYCLE_W-1:0]  instr_count_r;
    logic [NOP_W-1:0]    nop_run_r;
    logic                running_r;
    logic                halt_r;
    logic                is_nop_s;
    logic                nop_hit_s;
    logic                timeout_hit_s;

    assign is_nop_s      = instr_valid && (instr == DATA_W'(MIPS_NOP));
    // Trigger conditions look at the pre-increment value so the halt lands
    // on the same edge as the retirement / cycle that reaches the limit.
    assign nop_hit_s     = is_nop_s && (nop_run_r == NOP_W'(NOP_LIMIT - 1));
    assign timeout_hit_s = (cycle_count_r == CYCLE_W'(MAX_CYCLES - 1));

    assign running     = running_r;
    assign halt        = halt_r;
    assign halt_cause  = cause_r;
    assign cycle_count = cycle_count_r;
    assign instr_count = instr_count_r;

    // Run-control FSM with counters and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            cause_r       <= CAUSE_NONE;
            cycle_count_r <= {CYCLE_W{1'b0}};
            instr_count_r <= {CYCLE_W{1'b0}};
            nop_run_r     <= {NOP_W{1'b0}};
            running_r     <= 1'b0;
            halt_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state_r       <= ST_RUN;
                        cause_r       <= CAUSE_NONE;
                        cycle_count_r <= {CYCLE_W{1'b0}};
                        instr_count_r <= {CYCLE_W{1'b0}};
                        nop_run_r     <= {NOP_W{1'b0}};
                        running_r     <= 1'b1;
                        halt_r        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cycle_count_r <= cycle_count_r + CYC_ONE;
                    if (instr_valid) begin
                        instr_count_r <= instr_count_r + CYC_ONE;
                        nop_run_r     <= is_nop_s ? (nop_run_r + NOP_ONE) : {NOP_W{1'b0}};
                    end
                    // NOP limit takes priority when both triggers coincide.
                    if (nop_hit_s) begin
                        state_r   <= ST_HALTED;
                        cause_r   <= CAUSE_NOP;
                        running_r <= 1'b0;
                        halt_r    <= 1'b1;
                    end else if (timeout_hit_s) begin
                        state_r   <= ST_HALTED;
                        cause_r   <= CAUSE_TIMEOUT;
                        running_r <= 1'b0;
                        halt_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cause_r   <= CAUSE_NONE;
                    running_r <= 1'b0;
                    halt_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef MIPS_TRACE_FIFO_EN
    logic fifo_full_s;
    logic fifo_empty_s;
    logic push_s;
    logic flush_s;
    logic overflow_r;

    assign push_s  = (state_r == ST_RUN) && instr_valid && !is_nop_s;
    // Any accepted start (i.e. from IDLE or HALTED) begins a fresh trace.
    assign flush_s = start && (state_r != ST_RUN);

    mips_trace_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_s),
        .push      (push_s),
        .push_data ({instr, alu_result}),
        .pop       (trace_rd),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (trace_data)
    );

    // Sticky overflow: a push into a full FIFO with no simultaneous pop is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (flush_s) begin
            overflow_r <= 1'b0;
        end else if (push_s && fifo_full_s && !trace_rd) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign trace_valid    = !fifo_empty_s;
    assign trace_overflow = overflow_r;
`else
    logic unused_trace_s;

    assign unused_trace_s = ^{trace_rd, alu_result};
    assign trace_valid    = 1'b0;
    assign trace_data     = {(2*DATA_W){1'b0}};
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// Testbench for mips_run_monitor. Stimulus drives inputs on the falling edge
// and pushes the reference model's expected post-edge outputs into a queue;
// a separate monitor pops one entry per rising edge and compares.
module tb_mips_run_monitor;

    localparam int DATA_W      = 32;
    localparam int NOP_LIMIT   = 4;
    localparam int MAX_CYCLES  = 20;
    localparam int CYCLE_W     = 16;
    localparam int TRACE_DEPTH = 4;
`ifdef MIPS_TRACE_FIFO_EN
    localparam bit TRACE_EN = 1'b1;
`else
    localparam bit TRACE_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                instr_valid = 1'b0;
    logic [DATA_W-1:0]   instr = 32'h0;
    logic [DATA_W-1:0]   alu_result = 32'h0;
    logic                trace_rd = 1'b0;
    logic                running;
    logic                halt;
    logic [1:0]          halt_cause;
    logic [CYCLE_W-1:0]  cycle_count;
    logic [CYCLE_W-1:0]  instr_count;
    logic                trace_valid;
    logic [2*DATA_W-1:0] trace_data;
    logic                trace_overflow;

    mips_run_monitor #(
        .DATA_W      (DATA_W),
        .NOP_LIMIT   (NOP_LIMIT),
        .MAX_CYCLES  (MAX_CYCLES),
        .CYCLE_W     (CYCLE_W),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .alu_result     (alu_result),
        .running        (running),
        .halt           (halt),
        .halt_cause     (halt_cause),
        .cycle_count    (cycle_count),
        .instr_count    (instr_count),
        .trace_rd       (trace_rd),
        .trace_valid    (trace_valid),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        running;
        bit        halt;
        bit [1:0]  cause;
        bit [15:0] cyc;
        bit [15:0] icnt;
        bit        tvalid;
        bit [63:0] tdata;
        bit        tdata_chk;
        bit        tovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 idle, 1 run, 2 halted.
    int        m_mode;
    bit [1:0]  m_cause;
    bit [15:0] m_cyc;
    bit [15:0] m_icnt;
    int        m_nop;
    bit [63:0] m_tr[$];
    bit        m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cause = 2'd0; m_cyc = 16'd0; m_icnt = 16'd0;
        m_nop = 0; m_ovf = 1'b0; m_tr.delete();
    endtask

    task automatic model_step(input bit st, input bit iv, input bit [31:0] ins,
                              input bit [31:0] alu, input bit rd);
        bit   pop;
        bit   push;
        bit   nop_hit;
        exp_t e;
        pop     = TRACE_EN && rd && (m_tr.size() > 0);
        push    = 1'b0;
        nop_hit = 1'b0;
        if (m_mode == 1) begin
            push = TRACE_EN && iv && (ins != 32'h0);
            m_cyc++;
            if (iv) m_icnt++;
            if (iv && ins == 32'h0) begin
                m_nop++;
                nop_hit = (m_nop == NOP_LIMIT);
            end else if (iv) begin
                m_nop = 0;
            end
            if (pop) begin
                void'(m_tr.pop_front());
                if (push) m_tr.push_back({ins, alu});
            end else if (push) begin
                if (m_tr.size() == TRACE_DEPTH) m_ovf = 1'b1;
                else m_tr.push_back({ins, alu});
            end
            if (nop_hit) begin
                m_mode = 2; m_cause = 2'd1;
            end else if (m_cyc == MAX_CYCLES) begin
                m_mode = 2; m_cause = 2'd2;
            end
        end else begin
            if (pop) void'(m_tr.pop_front());
            if (st) begin
                m_mode = 1; m_cause = 2'd0; m_cyc = 16'd0; m_icnt = 16'd0;
                m_nop = 0; m_ovf = 1'b0; m_tr.delete();
            end
        end
        e.running   = (m_mode == 1);
        e.halt      = (m_mode == 2);
        e.cause     = m_cause;
        e.cyc       = m_cyc;
        e.icnt      = m_icnt;
        e.tvalid    = (m_tr.size() > 0);
        e.tdata     = (m_tr.size() > 0) ? m_tr[0] : 64'h0;
        e.tdata_chk = !TRACE_EN || (m_tr.size() > 0);
        e.tovf      = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit st, input bit iv, input bit [31:0] ins,
                        input bit [31:0] alu, input bit rd);
        @(negedge clk);
        start = st; instr_valid = iv; instr = ins; alu_result = alu; trace_rd = rd;
        model_step(st, iv, ins, alu, rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; instr_valid = 1'b0; instr = 32'h0;
        alu_result = 32'h0; trace_rd = 1'b0;
        model_reset();
        #1;
        chk("rst_running", running, 64'd0);
        chk("rst_halt", halt, 64'd0);
        chk("rst_cause", halt_cause, 64'd0);
        chk("rst_cycle_count", cycle_count, 64'd0);
        chk("rst_instr_count", instr_count, 64'd0);
        chk("rst_trace_valid", trace_valid, 64'd0);
        chk("rst_trace_data", trace_data, 64'd0);
        chk("rst_trace_overflow", trace_overflow, 64'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: compares DUT outputs after every edge that has an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("running", running, e.running);
                chk("halt", halt, e.halt);
                chk("halt_cause", halt_cause, e.cause);
                chk("cycle_count", cycle_count, e.cyc);
                chk("instr_count", instr_count, e.icnt);
                chk("trace_valid", trace_valid, e.tvalid);
                if (e.tdata_chk) chk("trace_data", trace_data, e.tdata);
                chk("trace_overflow", trace_overflow, e.tovf);
            end
        end
    end

    function automatic bit [31:0] rand_op();
        return $urandom | 32'h1;
    endfunction

    initial begin
        do_reset();
        idle(2);

        // NOP halt with 3 trace entries, a read in HALTED, then re-arm flushes.
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h200a000a, 32'd10, 1'b0);
        step(1'b0, 1'b1, 32'h20140014, 32'd20, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h201e001e, 32'd30, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Timeout: NOP,NOP,non-NOP never reaches the NOP limit.
        for (int i = 0; i < 24; i++)
            step(1'b0, 1'b1, (i % 3 == 2) ? rand_op() : 32'h0, $urandom, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Overflow: 6 pushes into depth 4, then push+pop while full, then NOP halt.
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rand_op(), $urandom, 1'b0);
        step(1'b0, 1'b1, rand_op(), $urandom, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Timeout cycle coincides with the 4th consecutive NOP.
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, rand_op(), $urandom, $urandom_range(0, 1) == 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        idle(2);

        // Reset mid-run after 7 cycles, then a fresh run from zero.
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, rand_op(), $urandom, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, $urandom_range(0, 1) == 1, rand_op(), $urandom, 1'b0);

        // Random traffic, including ignored starts while running.
        for (int i = 0; i < 600; i++) begin
            bit st;
            bit iv;
            bit [31:0] ins;
            st  = ($urandom_range(0, 15) == 0);
            iv  = ($urandom_range(0, 9) < 7);
            ins = ($urandom_range(0, 9) < 4) ? 32'h0 : rand_op();
            step(st, iv, ins, $urandom, $urandom_range(0, 9) < 3);
        end

        idle(2);
        @(negedge clk);
        start = 1'b0; instr_valid = 1'b0; trace_rd = 1'b0;
        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
